// File: rtl/spi_master_multi.sv
// SPI master with software-held active-low selects, MISO mix with default line,
// programmable half-period divider, all four SPI modes and a start/done handshake.
module spi_master_multi #(
    parameter int NSS   = 2,
    parameter int WIDTH = 8,
    parameter int DIVW  = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cfg_we,
    input  logic [NSS-1:0]   i_cfg_ss,
    input  logic [DIVW-1:0]  i_cfg_div,
    input  logic [1:0]       i_cfg_mode,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_txd,
    output logic [WIDTH-1:0] o_rxd,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_sck,
    output logic             o_mosi,
    output logic [NSS-1:0]   o_nss,
    input  logic [NSS:0]     i_miso
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;
    localparam int         KW      = $clog2(2 * WIDTH + 1);

    logic [0:0]       r_state;
    logic [NSS-1:0]   r_ss;
    logic [DIVW-1:0]  r_div;
    logic [1:0]       r_mode;
    logic             r_sck;
    logic             r_mosi;
    logic [WIDTH-1:0] r_rxd;
    logic             r_done;
    logic [WIDTH-1:0] r_shift;
    logic [DIVW-1:0]  r_cnt;
    logic [KW-1:0]    r_k;

    logic             w_miso;
    logic [KW-1:0]    w_k_next;
    logic             w_last;
    logic             w_sample;
    logic             w_drive;
    logic [WIDTH-1:0] w_shift_smp;

    // Selected lines are ORed; with no select asserted the default line is used.
    always_comb begin
        w_miso = |(i_miso[NSS-1:0] & r_ss);
        if (r_ss == '0) begin
            w_miso = i_miso[NSS];
        end
    end

    always_comb begin
        w_k_next    = r_k + KW'(1);
        w_last      = (w_k_next == KW'(2 * WIDTH));
        w_sample    = r_mode[0] ? ~w_k_next[0] : w_k_next[0];
        w_drive     = r_mode[0] ? (w_k_next[0] && (w_k_next != KW'(1)))
                                : (~w_k_next[0] && !w_last);
        w_shift_smp = {r_shift[WIDTH-2:0], w_miso};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_ss    <= '0;
            r_div   <= '0;
            r_mode  <= '0;
            r_sck   <= 1'b0;
            r_mosi  <= 1'b0;
            r_rxd   <= '0;
            r_done  <= 1'b0;
            r_shift <= '0;
            r_cnt   <= '0;
            r_k     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_cfg_we) begin
                        r_ss   <= i_cfg_ss;
                        r_div  <= i_cfg_div;
                        r_mode <= i_cfg_mode;
                        r_sck  <= i_cfg_mode[1];
                    end
                    // A same-cycle config write takes effect before the transfer starts.
                    if (i_start) begin
                        r_shift <= i_txd;
                        r_mosi  <= i_txd[WIDTH-1];
                        r_cnt   <= i_cfg_we ? i_cfg_div : r_div;
                        r_k     <= '0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (r_cnt == '0) begin
                        r_cnt <= r_div;
                        r_sck <= ~r_sck;
                        r_k   <= w_k_next;
                        if (w_sample) begin
                            r_shift <= w_shift_smp;
                        end
                        if (w_drive) begin
                            r_mosi <= r_shift[WIDTH-1];
                        end
                        // Final edge: in CPHA=1 it is also the last sample edge.
                        if (w_last) begin
                            r_state <= S_IDLE;
                            r_rxd   <= w_sample ? w_shift_smp : r_shift;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - DIVW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_rxd  = r_rxd;
    assign o_busy = (r_state == S_SHIFT);
    assign o_done = r_done;
    assign o_sck  = r_sck;
    assign o_mosi = r_mosi;
    assign o_nss  = ~r_ss;

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed and randomized checks of spi_master_multi against a protocol-level
// slave model and an arithmetic timing/result model.
module tb_spi_master_multi;

    logic       clk = 1'b0;
    logic       i_rst;
    logic       i_cfg_we;
    logic [1:0] i_cfg_ss;
    logic [7:0] i_cfg_div;
    logic [1:0] i_cfg_mode;
    logic       i_start;
    logic [7:0] i_txd;
    logic [7:0] o_rxd;
    logic       o_busy;
    logic       o_done;
    logic       o_sck;
    logic       o_mosi;
    logic [1:0] o_nss;
    logic [2:0] i_miso;

    always #5 clk = ~clk;

    spi_master_multi #(.NSS(2), .WIDTH(8), .DIVW(8)) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_cfg_we   (i_cfg_we),
        .i_cfg_ss   (i_cfg_ss),
        .i_cfg_div  (i_cfg_div),
        .i_cfg_mode (i_cfg_mode),
        .i_start    (i_start),
        .i_txd      (i_txd),
        .o_rxd      (o_rxd),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_sck      (o_sck),
        .o_mosi     (o_mosi),
        .o_nss      (o_nss),
        .i_miso     (i_miso)
    );

    int checks = 0;
    int errors = 0;

    // Model of the configuration registers.
    logic [1:0] m_ss;
    logic [7:0] m_div;
    logic [1:0] m_mode;

    // Per-line slave behaviour: fixed word, loopback of MOSI, or random noise.
    logic [7:0] line_word [3];
    logic       lw_loop   [3];
    logic       lw_noise  [3];

    // Transfer options.
    logic       opt_cfg = 1'b0;
    logic [1:0] oc_ss;
    logic [7:0] oc_div;
    logic [1:0] oc_mode;
    logic       opt_perturb = 1'b0;
    int         opt_abort = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_line(input int i, input logic [7:0] w, input logic lp, input logic nz);
        line_word[i] = w;
        lw_loop[i]   = lp;
        lw_noise[i]  = nz;
    endtask

    // A slave shifts its word out MSB first: CPHA=0 presents a new bit after each
    // trailing (even) edge, CPHA=1 after each leading (odd) edge.
    task automatic drive_miso(input int e, input logic cpha);
        for (int i = 0; i < 3; i++) begin
            int idx;
            logic [7:0] w;
            w   = line_word[i];
            idx = cpha ? ((e == 0) ? 7 : 7 - (e - 1) / 2) : 7 - e / 2;
            if (lw_loop[i])       i_miso[i] = o_mosi;
            else if (lw_noise[i]) i_miso[i] = 1'($urandom);
            else                  i_miso[i] = (idx >= 0) ? w[idx] : 1'b0;
        end
    endtask

    function automatic logic [7:0] exp_rx(input logic [7:0] txd);
        logic [7:0] w [3];
        logic [7:0] r;
        for (int i = 0; i < 3; i++) w[i] = lw_loop[i] ? txd : line_word[i];
        if (m_ss == 2'b00) return w[2];
        r = '0;
        for (int i = 0; i < 2; i++) if (m_ss[i]) r = r | w[i];
        return r;
    endfunction

    task automatic cfg_write(input logic [1:0] ss, input logic [7:0] div, input logic [1:0] mode);
        logic [1:0] nss_exp;
        i_cfg_we   = 1'b1;
        i_cfg_ss   = ss;
        i_cfg_div  = div;
        i_cfg_mode = mode;
        @(posedge clk); @(negedge clk);
        i_cfg_we = 1'b0;
        m_ss = ss; m_div = div; m_mode = mode;
        nss_exp = ~ss;
        chk("cfg_sck_cpol", o_sck, mode[1]);
        chk("cfg_nss", o_nss, nss_exp);
    endtask

    task automatic xfer(input logic [7:0] txd);
        int e, last, d, j;
        logic cpha, cpol, prev, early, nss_bad;
        logic [7:0] exp;
        logic [7:0] inv;
        logic [1:0] nss_exp;
        if (opt_cfg) begin
            i_cfg_we = 1'b1; i_cfg_ss = oc_ss; i_cfg_div = oc_div; i_cfg_mode = oc_mode;
            m_ss = oc_ss; m_div = oc_div; m_mode = oc_mode;
        end
        i_start = 1'b1;
        i_txd   = txd;
        d       = int'(m_div);
        cpha    = m_mode[0];
        cpol    = m_mode[1];
        last    = 1 + 16 * (d + 1);
        exp     = exp_rx(txd);
        nss_exp = ~m_ss;
        inv     = ~txd;
        e = 0; prev = cpol; early = 1'b0; nss_bad = 1'b0;
        drive_miso(0, cpha);
        @(posedge clk); @(negedge clk);
        i_start  = 1'b0;
        i_cfg_we = 1'b0;
        for (int n = 1; n <= last; n++) begin
            if (n == 1) chk("busy_rise", o_busy, 1'b1);
            if (o_nss !== nss_exp) nss_bad = 1'b1;
            if (o_sck !== prev) begin
                e++;
                prev = o_sck;
                if (cpha ? (e % 2 == 0) : (e % 2 == 1)) begin
                    j = cpha ? e / 2 : (e + 1) / 2;
                    chk("mosi_bit", o_mosi, txd[8-j]);
                end
            end
            if (n == last) begin
                chk("no_early_done", early, 1'b0);
                chk("sck_edges", e, 16);
                chk("done_pulse", o_done, 1'b1);
                chk("busy_fall", o_busy, 1'b0);
                chk("rxd", o_rxd, exp);
                chk("sck_idle", o_sck, cpol);
                chk("nss_steady", nss_bad, 1'b0);
            end else begin
                if (o_done) early = 1'b1;
                if (opt_abort != 0 && e == opt_abort) begin
                    i_rst = 1'b1;
                    @(posedge clk); @(negedge clk);
                    i_rst = 1'b0;
                    m_ss = '0; m_div = '0; m_mode = '0;
                    chk("abort_no_early_done", early, 1'b0);
                    chk("abort_busy", o_busy, 1'b0);
                    chk("abort_sck", o_sck, 1'b0);
                    chk("abort_nss", o_nss, 2'b11);
                    chk("abort_rxd", o_rxd, 8'h00);
                    chk("abort_done", o_done, 1'b0);
                    @(posedge clk); @(negedge clk);
                    chk("abort_no_done_later", o_done, 1'b0);
                    return;
                end
                // Config writes and starts while busy must be dropped.
                if (opt_perturb && (n == 5 || n == 20)) begin
                    i_cfg_we = 1'b1; i_cfg_ss = ~m_ss; i_cfg_div = 8'd7; i_cfg_mode = ~m_mode;
                    i_start  = 1'b1; i_txd = inv;
                end else begin
                    i_cfg_we = 1'b0;
                    i_start  = 1'b0;
                end
                drive_miso(e, cpha);
                @(posedge clk); @(negedge clk);
            end
        end
        i_cfg_we = 1'b0;
        i_start  = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("done_one_cycle", o_done, 1'b0);
    endtask

    initial begin
        i_rst = 1'b1; i_cfg_we = 1'b0; i_cfg_ss = '0; i_cfg_div = '0; i_cfg_mode = '0;
        i_start = 1'b0; i_txd = '0; i_miso = '0;
        for (int i = 0; i < 3; i++) set_line(i, 8'h00, 1'b0, 1'b0);
        m_ss = '0; m_div = '0; m_mode = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        i_rst = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("reset_nss", o_nss, 2'b11);
        chk("reset_sck", o_sck, 1'b0);
        chk("reset_busy", o_busy, 1'b0);
        chk("reset_done", o_done, 1'b0);
        chk("reset_rxd", o_rxd, 8'h00);
        chk("reset_mosi", o_mosi, 1'b0);

        // Mode 0, DIV=0, loopback on line 0.
        cfg_write(2'b01, 8'd0, 2'b00);
        set_line(0, 8'h00, 1'b1, 1'b0);
        set_line(1, 8'($urandom), 1'b0, 1'b0);
        set_line(2, 8'h00, 1'b0, 1'b1);
        xfer(8'hA5);

        // Mode 3, DIV=3, slave on line 1 returns 0x3C, line 0 toggles.
        cfg_write(2'b10, 8'd3, 2'b11);
        set_line(0, 8'h00, 1'b0, 1'b1);
        set_line(1, 8'h3C, 1'b0, 1'b0);
        set_line(2, 8'h00, 1'b0, 1'b0);
        xfer(8'($urandom));

        // Config in the START cycle; writes and starts while busy.
        cfg_write(2'b01, 8'd1, 2'b00);
        set_line(0, 8'h00, 1'b1, 1'b0);
        set_line(1, 8'h00, 1'b0, 1'b1);
        set_line(2, 8'h00, 1'b0, 1'b1);
        opt_cfg = 1'b1; oc_ss = 2'b01; oc_div = 8'd2; oc_mode = 2'b00;
        opt_perturb = 1'b1;
        xfer(8'($urandom));
        opt_cfg = 1'b0; opt_perturb = 1'b0;

        // Reset at SCK edge 5, then a normal transfer.
        cfg_write(2'b11, 8'd1, 2'b01);
        opt_abort = 5;
        xfer(8'($urandom));
        opt_abort = 0;
        cfg_write(2'b01, 8'd0, 2'b10);
        xfer(8'($urandom));

        // Default line when nothing selected; OR of two selected lines.
        cfg_write(2'b00, 8'd0, 2'b00);
        set_line(0, 8'h00, 1'b0, 1'b0);
        set_line(1, 8'h00, 1'b0, 1'b0);
        set_line(2, 8'hFF, 1'b0, 1'b0);
        xfer(8'($urandom));
        cfg_write(2'b11, 8'd0, 2'b00);
        set_line(1, 8'h0F, 1'b0, 1'b0);
        set_line(2, 8'h00, 1'b0, 1'b1);
        xfer(8'($urandom));

        // Randomized transfers.
        for (int r = 0; r < 8; r++) begin
            set_line(0, 8'($urandom), 1'($urandom), 1'b0);
            set_line(1, 8'($urandom), 1'b0, 1'b0);
            set_line(2, 8'h00, 1'b0, 1'b1);
            cfg_write(2'($urandom_range(1, 3)), 8'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            xfer(8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
